// File: rtl/residual_popcount_acc_if.sv
// Beat/result handshake bundle for residual_popcount_acc.
// The master modport is the producer/consumer side; the slave modport is the accumulator.
interface residual_popcount_acc_if #(
  parameter int LEVELS  = 2,
  parameter int SIMD    = 4,
  parameter int GAMMA_W = 8,
  parameter int ACC_W   = 16
);
  logic                        start;
  logic [LEVELS*GAMMA_W-1:0]   gamma;
  logic [LEVELS*SIMD-1:0]      in_bits;
  logic [SIMD-1:0]             w;
  logic                        in_valid;
  logic                        in_ready;
  logic [ACC_W-1:0]            out_sum;
  logic                        out_valid;
  logic                        out_ready;
  logic                        sat;
  logic                        busy;

  modport master (
    output start, gamma, in_bits, w, in_valid, out_ready,
    input  in_ready, out_sum, out_valid, sat, busy
  );

  modport slave (
    input  start, gamma, in_bits, w, in_valid, out_ready,
    output in_ready, out_sum, out_valid, sat, busy
  );
endinterface

// File: rtl/residual_popcount_acc.sv
// Residual binarized dot-product accumulator: XNOR-popcount per level, gamma-scaled, folded over FOLDS beats.
// Optional feature macro SATURATE_EN: clamp the accumulator at 2^ACC_W-1 and raise a sticky sat flag.
module residual_popcount_acc #(
  parameter int LEVELS  = 2,
  parameter int SIMD    = 4,
  parameter int GAMMA_W = 8,
  parameter int ACC_W   = 16,
  parameter int FOLDS   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  residual_popcount_acc_if.slave bus
);

  localparam int PC_W   = $clog2(SIMD + 1);
  localparam int PROD_W = PC_W + GAMMA_W;
  localparam int CON_W  = PROD_W + $clog2(LEVELS + 1);
  localparam int FC_W   = (FOLDS > 1) ? $clog2(FOLDS) : 1;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                    state;
  logic [ACC_W-1:0]          acc;
  logic [FC_W-1:0]           fold_cnt;
  logic [LEVELS*GAMMA_W-1:0] gamma_q;

  logic [PC_W-1:0]   pc;
  logic [PROD_W-1:0] prod;
  logic [CON_W-1:0]  contrib;
  logic [ACC_W-1:0]  acc_next;
  logic              beat;
  logic              load;

  // Handshake outputs depend only on the registered state, never on inputs.
  assign bus.in_ready  = (state == ACCUM);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_sum   = acc;

  assign beat = (state == ACCUM) && bus.in_valid;
  assign load = bus.start && ((state == IDLE) || ((state == DONE) && bus.out_ready));

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    pc      = '0;
    prod    = '0;
    contrib = '0;
    for (int l = 0; l < LEVELS; l++) begin
      pc = '0;
      for (int b = 0; b < SIMD; b++)
        pc = pc + PC_W'(~(bus.in_bits[l*SIMD + b] ^ bus.w[b]));
      prod    = PROD_W'(pc) * PROD_W'(gamma_q[l*GAMMA_W +: GAMMA_W]);
      contrib = contrib + CON_W'(prod);
    end
  end

`ifdef SATURATE_EN
  localparam int SUM_W = ((ACC_W > CON_W) ? ACC_W : CON_W) + 1;

  logic [SUM_W-1:0] sum_full;
  logic             sat_hit;
  logic             sat_q;

  always_comb begin
    sum_full = SUM_W'(acc) + SUM_W'(contrib);
    sat_hit  = |sum_full[SUM_W-1:ACC_W];
    acc_next = sat_hit ? '1 : sum_full[ACC_W-1:0];
  end

  assign bus.sat = sat_q;

  always_ff @(posedge clk) begin
    if (rst || load)
      sat_q <= 1'b0;
    else if (beat && sat_hit)
      sat_q <= 1'b1;
  end
`else
  assign acc_next = acc + ACC_W'(contrib);
  assign bus.sat  = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      fold_cnt <= '0;
      gamma_q  <= '0;
    end else if (load) begin
      // Covers both a fresh start from IDLE and a back-to-back restart out of DONE.
      state    <= ACCUM;
      acc      <= '0;
      fold_cnt <= '0;
      gamma_q  <= bus.gamma;
    end else begin
      case (state)
        ACCUM: begin
          if (beat) begin
            acc      <= acc_next;
            fold_cnt <= fold_cnt + FC_W'(1);
            if (fold_cnt == FC_W'(FOLDS - 1))
              state <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_residual_popcount_acc.sv
// Directed self-checking bench for residual_popcount_acc: default instance plus an ACC_W=10, FOLDS=2 overflow instance.
// Expected values are hand-computed; per-beat contrib for the default vector is 4*51 + 3*170 = 714.
module tb_residual_popcount_acc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  residual_popcount_acc_if #(.LEVELS(2), .SIMD(4), .GAMMA_W(8), .ACC_W(16)) bus_a ();
  residual_popcount_acc_if #(.LEVELS(2), .SIMD(4), .GAMMA_W(8), .ACC_W(10)) bus_b ();

  residual_popcount_acc #(.LEVELS(2), .SIMD(4), .GAMMA_W(8), .ACC_W(16), .FOLDS(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  residual_popcount_acc #(.LEVELS(2), .SIMD(4), .GAMMA_W(8), .ACC_W(10), .FOLDS(2)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge, away from the active edge.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic start_a(input logic [15:0] g);
    bus_a.gamma = g;
    bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
  endtask

  task automatic run_basic_a(input string tag);
    start_a(16'hAA33);
    check({tag, "_in_ready_after_start"}, 32'(bus_a.in_ready), 32'd1);
    bus_a.in_valid = 1'b1;
    step(3);
    check({tag, "_no_valid_after_3"}, 32'(bus_a.out_valid), 32'd0);
    step();
    bus_a.in_valid = 1'b0;
    check({tag, "_out_valid"}, 32'(bus_a.out_valid), 32'd1);
    check({tag, "_out_sum"}, 32'(bus_a.out_sum), 32'd2856);
    check({tag, "_sat"}, 32'(bus_a.sat), 32'd0);
  endtask

  task automatic consume_a();
    bus_a.out_ready = 1'b1;
    step();
    bus_a.out_ready = 1'b0;
  endtask

  initial begin
    bus_a.start = 1'b0; bus_a.gamma = '0; bus_a.in_bits = 8'b1011_0011; bus_a.w = 4'b0011;
    bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b0;
    bus_b.start = 1'b0; bus_b.gamma = '0; bus_b.in_bits = 8'b1011_0011; bus_b.w = 4'b0011;
    bus_b.in_valid = 1'b0; bus_b.out_ready = 1'b0;

    // Reset then idle.
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step();
    check("rst_in_ready", 32'(bus_a.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
    check("rst_out_sum", 32'(bus_a.out_sum), 32'd0);
    check("rst_sat", 32'(bus_a.sat), 32'd0);
    check("rst_busy", 32'(bus_a.busy), 32'd0);
    bus_a.in_valid = 1'b1;
    step(3);
    check("idle_in_ready", 32'(bus_a.in_ready), 32'd0);
    check("idle_out_valid", 32'(bus_a.out_valid), 32'd0);
    bus_a.in_valid = 1'b0;

    // Basic vector, result held while out_ready is low.
    run_basic_a("basic");
    step(2);
    check("basic_hold_valid", 32'(bus_a.out_valid), 32'd1);
    check("basic_hold_sum", 32'(bus_a.out_sum), 32'd2856);
    consume_a();
    check("basic_consumed_valid", 32'(bus_a.out_valid), 32'd0);
    check("basic_consumed_busy", 32'(bus_a.busy), 32'd0);

    // Stalled input; a start and gamma change mid-vector must be ignored.
    start_a(16'hAA33);
    for (int i = 0; i < 8; i++) begin
      bus_a.in_valid = (i % 2 == 0);
      if (i == 3) begin
        bus_a.start = 1'b1;
        bus_a.gamma = 16'h0101;
      end else begin
        bus_a.start = 1'b0;
      end
      step();
    end
    bus_a.in_valid = 1'b0;
    check("stall_out_valid", 32'(bus_a.out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("stall_hold_sum", 32'(bus_a.out_sum), 32'd2856);
      check("stall_hold_in_ready", 32'(bus_a.in_ready), 32'd0);
      step();
    end

    // Back-to-back restart from DONE with gamma=16'h0101.
    bus_a.gamma     = 16'h0101;
    bus_a.start     = 1'b1;
    bus_a.out_ready = 1'b1;
    step();
    bus_a.start     = 1'b0;
    bus_a.out_ready = 1'b0;
    check("b2b_in_ready", 32'(bus_a.in_ready), 32'd1);
    check("b2b_out_valid_low", 32'(bus_a.out_valid), 32'd0);
    check("b2b_acc_cleared", 32'(bus_a.out_sum), 32'd0);
    bus_a.in_valid = 1'b1;
    step(4);
    bus_a.in_valid = 1'b0;
    check("b2b_out_valid", 32'(bus_a.out_valid), 32'd1);
    check("b2b_out_sum", 32'(bus_a.out_sum), 32'd28);
    consume_a();

    // Reset mid-vector, then a clean vector.
    start_a(16'hAA33);
    bus_a.in_valid = 1'b1;
    step(2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_busy", 32'(bus_a.busy), 32'd0);
    check("midrst_in_ready", 32'(bus_a.in_ready), 32'd0);
    check("midrst_out_sum", 32'(bus_a.out_sum), 32'd0);
    step(3);
    check("midrst_no_valid", 32'(bus_a.out_valid), 32'd0);
    bus_a.in_valid = 1'b0;
    run_basic_a("after_rst");
    consume_a();

    // Overflow instance: 2 beats of 714 in a 10-bit accumulator.
    bus_b.gamma = 16'hAA33;
    bus_b.start = 1'b1;
    step();
    bus_b.start    = 1'b0;
    bus_b.in_valid = 1'b1;
    step();
    check("ovf_first_beat", 32'(bus_b.out_sum), 32'd714);
    step();
    bus_b.in_valid = 1'b0;
    check("ovf_out_valid", 32'(bus_b.out_valid), 32'd1);
`ifdef SATURATE_EN
    check("ovf_out_sum", 32'(bus_b.out_sum), 32'd1023);
    check("ovf_sat", 32'(bus_b.sat), 32'd1);
`else
    check("ovf_out_sum", 32'(bus_b.out_sum), 32'd404);
    check("ovf_sat", 32'(bus_b.sat), 32'd0);
`endif
    bus_b.out_ready = 1'b1;
    step();
    bus_b.out_ready = 1'b0;
    check("ovf_consumed", 32'(bus_b.out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
